// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared PIPE encodings and controller state type
package pipe_pkg;

   localparam logic [3:0] PD_P0  = 4'd0;
   localparam logic [3:0] PD_P0S = 4'd1;
   localparam logic [3:0] PD_P1  = 4'd2;
   localparam logic [3:0] PD_P2  = 4'd3;

   localparam logic [2:0] RXSTAT_RX_PRESENT = 3'b011;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DET_P1,
      ST_DET_RUN,
      ST_DONE,
      ST_PM_WAIT,
      ST_PM_ACK
   } lane_state_t;

   function automatic logic pd_legal(input logic [3:0] pd);
      return pd <= PD_P2;
   endfunction

endpackage

// File: rtl/pipe_lane_pwr_ctrl_if.sv
// rtl/pipe_lane_pwr_ctrl_if.sv - MAC/PHY PIPE lane control and status bundle
interface pipe_lane_pwr_ctrl_if #(
   parameter int NUM_LANES = 4
);
   logic [NUM_LANES-1:0]   TxDetectRx_Loopback;
   logic [3:0]             PowerDown;
   logic [NUM_LANES-1:0]   TxElecIdle;
   logic [NUM_LANES-1:0]   PhyStatus;
   logic [3*NUM_LANES-1:0] RxStatus;

   modport master (
      output TxDetectRx_Loopback, PowerDown, TxElecIdle,
      input  PhyStatus, RxStatus
   );

   modport slave (
      input  TxDetectRx_Loopback, PowerDown, TxElecIdle,
      output PhyStatus, RxStatus
   );
endinterface

// File: rtl/pipe_phystatus_collect.sv
// rtl/pipe_phystatus_collect.sv - sticky per-lane PhyStatus flags and wait timeout counter
module pipe_phystatus_collect #(
   parameter int NUM_LANES      = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 pclk,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic [NUM_LANES-1:0] phy_status,
   output logic [NUM_LANES-1:0] first_strobe,
   output logic                 all_done,
   output logic                 near_expiry,
   output logic                 expired
);
   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] WARN = CW'(TIMEOUT_CYCLES - 2);

   logic [NUM_LANES-1:0] flags;
   logic [CW-1:0]        count;

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         flags <= '0;
         count <= '0;
      end else if (clear) begin
         flags <= '0;
         count <= '0;
      end else begin
         flags <= flags | phy_status;
         if (count != LAST)
            count <= count + 1'b1;
      end
   end

   // Current-cycle strobes count toward completion so the FSM reacts one edge earlier.
   assign first_strobe = phy_status & ~flags;
   assign all_done     = &(flags | phy_status);
   assign near_expiry  = (count == WARN);
   assign expired      = (count == LAST);

endmodule

// File: rtl/pipe_lane_pwr_ctrl.sv
// rtl/pipe_lane_pwr_ctrl.sv - multi-lane PIPE receiver-detect, power-state and electrical-idle sequencer
module pipe_lane_pwr_ctrl
   import pipe_pkg::*;
#(
   parameter int NUM_LANES      = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 pclk,
   input  logic                 reset_n,
   input  logic [NUM_LANES-1:0] elec_idle_req,
   input  logic                 detect_req,
   input  logic                 pd_req,
   input  logic [3:0]           pd_target,
   pipe_lane_pwr_ctrl_if.master phy,
   output logic                 detect_done,
   output logic [NUM_LANES-1:0] detect_result,
   output logic                 pd_ack,
   output logic                 timeout_err,
   output logic                 busy
);
   lane_state_t          state;
   logic                 collect_clear;
   logic [NUM_LANES-1:0] first_strobe;
   logic [NUM_LANES-1:0] rx_present;
   logic                 all_done;
   logic                 near_expiry;
   logic                 expired;

   always_comb begin
      rx_present = '0;
      for (int i = 0; i < NUM_LANES; i++)
         rx_present[i] = (phy.RxStatus[3*i +: 3] == RXSTAT_RX_PRESENT);
   end

   // Flags and counter restart on every entry to a wait state; DET_P1 -> DET_RUN is the only wait-to-wait hop.
   assign collect_clear = !(state inside {ST_DET_P1, ST_DET_RUN, ST_PM_WAIT}) ||
                          (state == ST_DET_P1 && all_done);

   pipe_phystatus_collect #(
      .NUM_LANES      (NUM_LANES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_collect (
      .pclk         (pclk),
      .reset_n      (reset_n),
      .clear        (collect_clear),
      .phy_status   (phy.PhyStatus),
      .first_strobe (first_strobe),
      .all_done     (all_done),
      .near_expiry  (near_expiry),
      .expired      (expired)
   );

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         state                   <= ST_IDLE;
         phy.PowerDown           <= PD_P1;
         phy.TxElecIdle          <= '1;
         phy.TxDetectRx_Loopback <= '0;
         detect_done             <= 1'b0;
         detect_result           <= '0;
         pd_ack                  <= 1'b0;
         timeout_err             <= 1'b0;
         busy                    <= 1'b0;
      end else begin
         detect_done    <= 1'b0;
         pd_ack         <= 1'b0;
         timeout_err    <= 1'b0;
         phy.TxElecIdle <= elec_idle_req;
         case (state)
            ST_IDLE: begin
               if (detect_req) begin
                  detect_result  <= '0;
                  phy.PowerDown  <= PD_P1;
                  phy.TxElecIdle <= '1;
                  busy           <= 1'b1;
                  if (phy.PowerDown == PD_P1) begin
                     state                   <= ST_DET_RUN;
                     phy.TxDetectRx_Loopback <= '1;
                  end else begin
                     state <= ST_DET_P1;
                  end
               end else if (pd_req) begin
                  if (!pd_legal(pd_target)) begin
                     timeout_err <= 1'b1;
                  end else if (pd_target == phy.PowerDown) begin
                     pd_ack <= 1'b1;
                     busy   <= 1'b1;
                     state  <= ST_PM_ACK;
                  end else begin
                     phy.PowerDown <= pd_target;
                     busy          <= 1'b1;
                     state         <= ST_PM_WAIT;
                  end
               end
            end
            ST_DET_P1: begin
               if (all_done) begin
                  phy.TxElecIdle          <= '1;
                  phy.TxDetectRx_Loopback <= '1;
                  state                   <= ST_DET_RUN;
               end else if (expired) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  phy.TxElecIdle <= '1;
                  timeout_err    <= near_expiry;
               end
            end
            ST_DET_RUN: begin
               phy.TxElecIdle <= '1;
               detect_result  <= detect_result | (first_strobe & rx_present);
               if (all_done || expired) begin
                  phy.TxDetectRx_Loopback <= '0;
                  detect_done             <= 1'b1;
                  state                   <= ST_DONE;
               end else begin
                  timeout_err <= near_expiry;
               end
            end
            ST_PM_WAIT: begin
               if (all_done) begin
                  pd_ack <= 1'b1;
                  state  <= ST_PM_ACK;
               end else if (expired) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  timeout_err <= near_expiry;
               end
            end
            ST_DONE, ST_PM_ACK: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/pipe_lane_pwr_ctrl.md
# pipe_lane_pwr_ctrl

Multi-lane PIPE MAC-side controller for receiver detection, power-state changes and TX electrical idle across `NUM_LANES` lanes. It sits between the LTSSM and the PIPE PHY interface. It sequences `PowerDown`, `TxDetectRx_Loopback` and `TxElecIdle`, collects per-lane `PhyStatus` / `RxStatus` completions, and returns per-lane detect results plus a timeout error. This is the parametrised successor to the single-lane detect/idle control, adding:

- explicit power-state handshakes
- per-lane results
- a bounded wait

## Interface
Parameters:
- `NUM_LANES`, 4, number of PIPE lanes (1..16)
- `TIMEOUT_CYCLES`, 1024, maximum pclk cycles spent waiting for `PhyStatus` in any wait state (≥2)

Ports:
- `pclk`  in  1  PIPE clock
- `reset_n`  in  1  asynchronous, active-low reset
- `elec_idle_req`  in  NUM_LANES  per-lane TX electrical-idle request from LTSSM
- `detect_req`  in  1  single-cycle pulse: start receiver detection
- `pd_req`  in  1  single-cycle pulse: change power state to `pd_target`
- `pd_target`  in  4  requested PowerDown encoding (0=P0, 1=P0s, 2=P1, 3=P2)
- `PhyStatus`  in  NUM_LANES  per-lane PHY completion strobe
- `RxStatus`  in  3*NUM_LANES  per-lane status; lane i at [3i+2:3i]
- `TxDetectRx_Loopback`  out  NUM_LANES  per-lane detect request to PHY
- `PowerDown`  out  4  common power state to all lanes
- `TxElecIdle`  out  NUM_LANES  per-lane TX electrical idle
- `detect_done`  out  1  one-cycle pulse: detection finished
- `detect_result`  out  NUM_LANES  lane i = receiver detected; held until next detect
- `pd_ack`  out  1  one-cycle pulse: power change completed
- `timeout_err`  out  1  one-cycle pulse: wait expired or illegal `pd_target`
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
Reset values:
- `PowerDown`=4'd2 (P1), `TxElecIdle`=all ones
- `TxDetectRx_Loopback`, `detect_done`, `detect_result`, `pd_ack`, `timeout_err`=0
- state=IDLE, lane flags cleared

States:
- **IDLE.** Accepts requests; `busy`=0.
  - `detect_req` → DET_P1, or directly DET_RUN if `PowerDown` is already P1.
  - `pd_req` → PM_WAIT.
  - Both in the same cycle: detect wins, `pd_req` dropped.
  - Requests outside IDLE are ignored.
- **DET_P1.** Drives `PowerDown`=P1. Waits until every lane has pulsed `PhyStatus` → DET_RUN.
- **DET_RUN.** Drives `TxDetectRx_Loopback`=all ones.
  - On lane i's first `PhyStatus` in this state, latch `detect_result[i]` = (`RxStatus`[i]==3'b011); any other code → 0.
  - All lanes flagged → DONE.
- **DONE.** Single cycle: `TxDetectRx_Loopback`=0, `detect_done`=1 → IDLE. `PowerDown` stays P1.
- **PM_WAIT.** Drives `PowerDown`=`pd_target`. All lanes flagged → `pd_ack` pulse, → IDLE.

Lane-completion flags:
- Per-lane flags are sticky and cleared on every state entry.
- Repeated `PhyStatus` on an already-flagged lane is ignored.

`TxElecIdle`:
- Forced all ones in DET_P1, DET_RUN and DONE.
- Otherwise equals `elec_idle_req` registered, with 1-cycle latency.

Boundary conditions:
- `pd_target` equal to the current `PowerDown`: `pd_ack` the next cycle, no PhyStatus wait.
- `pd_target` > 3: request rejected, `timeout_err` pulse the next cycle, no state change.
- Timeout counter: reset on entry to each wait state. When it reaches `TIMEOUT_CYCLES`-1:
  - `timeout_err` pulses.
  - In DET_RUN: unfinished lanes report 0, then DONE runs (`detect_done` still pulses).
  - In DET_P1: → IDLE with no `detect_done`.
  - In PM_WAIT: → IDLE with no `pd_ack`; `PowerDown` keeps the target value.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous).

## Timing
- All outputs are registered.
- Detect from P0, with `detect_req` at cycle 0:
  - `PowerDown`=2 and `busy`=1 from cycle 1.
  - `TxDetectRx_Loopback` rises the cycle after the last lane's `PhyStatus` in DET_P1.
  - `detect_done` rises the cycle after the last lane's `PhyStatus` in DET_RUN, coincident with `TxDetectRx_Loopback` falling.
- `detect_result` is valid from the `detect_done` cycle onward.
- `pd_ack` rises the cycle after the last-lane `PhyStatus`. `busy` falls the cycle after the `pd_ack` / `detect_done` cycle.
- Minimum detect latency from P1: 3 cycles (request, lane `PhyStatus` in DET_RUN, DONE).

## Structure
- Shared package `pipe_pkg`:
  - PowerDown encodings `PD_P0`/`PD_P0S`/`PD_P1`/`PD_P2`
  - `RXSTAT_RX_PRESENT`=3'b011
  - FSM state enum
- Sub-module `pipe_phystatus_collect`: per-lane sticky flags, `all_done`, clear input, and the timeout counter with `expired` output. It is instantiated once and shared by all wait states.

## Test plan
- NUM_LANES=4, P0, `detect_req`; PhyStatus per lane with RxStatus 011, 011, 000, 011 → `PowerDown`=2, then `detect_done` with `detect_result`=4'b1011 and `TxDetectRx_Loopback`=0.
- Lanes' `PhyStatus` skewed 0/5/9/20 cycles in PM_WAIT, `pd_target`=0 from P1 → `pd_ack` exactly 1 cycle after the lane-3 strobe; duplicate lane-0 strobes ignored.
- TIMEOUT_CYCLES=16, lane 2 never responds in DET_RUN → `timeout_err` at cycle 15 of the state, `detect_done` next, `detect_result[2]`=0.
- `detect_req` and `pd_req` in the same cycle → detection runs, no `pd_ack`; `pd_target`=7 → `timeout_err` 1 cycle later, `PowerDown` unchanged.
- `reset_n` low during DET_RUN → `PowerDown`=2, `TxElecIdle`=4'hF, `TxDetectRx_Loopback`=0, `busy`=0 immediately; `elec_idle_req`=4'b0101 in IDLE → `TxElecIdle`=4'b0101 one cycle later.
